watch_mode_ctrl: RTL and testbench
==================================

# watch_mode_ctrl

Button-driven mode and time-set controller for the watch chip. It converts debounced push-button levels into mode state, one-cycle hour/minute increment and decrement pulses, and stopwatch run/clear controls. Its outputs feed the time-keeping counter (`clock_enable`, `min_inc`, `min_dec`, `hour_inc`, `hour_dec`) and the display blanking logic. It runs on the system clock and uses a 1 Hz strobe for blink and timeout.

## Interface
- `REPEAT_DELAY`, default 8: clk cycles a button is held after its initial pulse before the first auto-repeat pulse; minimum 2.
- `REPEAT_PERIOD`, default 4: clk cycles between consecutive auto-repeat pulses; minimum 2.
- `TIMEOUT_SEC`, default 10: `tick_1hz` strobes without activity before a set mode returns to TIME; minimum 1.
- `clk` input 1: system clock.
- `reset` input 1: reset, synchronous, active-high.
- `tick_1hz` input 1: one-clk-wide strobe, once per second.
- `btn_mode`, `btn_up`, `btn_down`, `btn_start` input 1 each: debounced, synchronized button levels, 1 = pressed.
- `mode` output 2: 0 TIME, 1 SET_HOUR, 2 SET_MIN, 3 STOPWATCH.
- `clock_enable` output 1: 1 = display current time, 0 = display stopwatch.
- `hour_inc`, `hour_dec`, `min_inc`, `min_dec` output 1 each: one-clk adjust pulses.
- `sw_run` output 1: stopwatch running level.
- `sw_clear` output 1: one-clk stopwatch clear pulse.
- `blank_hours`, `blank_mins` output 1 each: display blink blanking.

## Operation
- Rising edge of a button: its sampled level is 1 while its registered previous level is 0. All outputs are registered.
- Button level registers, `mode`, and all counters are cleared by `reset`.
- Reset values:
  - `mode` = 0 (TIME), `clock_enable` = 1, `sw_run` = 0.
  - All pulses = 0, both blanks = 0, blink phase = 0.
- `btn_mode` rising edge advances the mode: TIME→SET_HOUR→SET_MIN→STOPWATCH→TIME.
  - It takes priority: `btn_up`/`btn_down` edges in the same cycle are ignored.
  - Entering any state clears the hold, blink and timeout counters.
- In TIME, `btn_up`, `btn_down` and `btn_start` are ignored.
- In SET_HOUR: `btn_up` edge → `hour_inc` pulse; `btn_down` edge → `hour_dec` pulse.
- In SET_MIN: `btn_up` edge → `min_inc` pulse; `btn_down` edge → `min_dec` pulse.
- Up and down edges in the same cycle, or either edge while the other button is held: no pulse, and auto-repeat is inhibited until both buttons are released.
- Auto-repeat, SET states only:
  - Holding exactly one of up/down produces a repeat pulse REPEAT_DELAY cycles after the initial pulse.
  - Further repeat pulses follow every REPEAT_PERIOD cycles.
  - Release stops repeat immediately; no pulse is issued in the release cycle.
- Timeout, SET states only:
  - The counter increments on `tick_1hz`.
  - It is held at 0 while any button is high or an edge occurs.
  - When it reaches TIMEOUT_SEC, `mode` becomes TIME.
  - A `tick_1hz` coincident with a button edge counts as activity, so no increment.
- Blink: the phase toggles on each `tick_1hz` in SET states.
  - `blank_hours` = SET_HOUR ∧ phase ∧ ¬(`btn_up` ∨ `btn_down`).
  - `blank_mins` is the same with SET_MIN.
  - Both blanks are 0 in other modes.
- STOPWATCH:
  - `btn_start` edge toggles `sw_run`.
  - `btn_down` edge while `sw_run` = 0 → `sw_clear` pulse.
  - `btn_down` edge while running is ignored.
  - `btn_up` is ignored.
- `sw_run` persists across mode changes (the stopwatch keeps running in the background). Only `reset` or `btn_start` in STOPWATCH change it.
- `clock_enable` = 0 only when `mode` = 3.
- Adjust pulses are never asserted in TIME or STOPWATCH.

## Timing
- Edge sampled at clk edge n → pulse or mode change visible after edge n+1 (latency 1). Each pulse is exactly 1 cycle wide.
- `mode` and `clock_enable` change in the same cycle.
- `reset` mid-hold or mid-timeout aborts the operation. No pulse follows the reset. A button already held at reset release gives no edge until it is re-pressed.
- `tick_1hz` is assumed to be at least 2 clk apart; back-to-back ticks are each counted.

## Configuration
- `WATCH_AUTOREPEAT_EN` defined: auto-repeat logic and the hold counter are compiled in, as described above.
- Undefined: each up/down press yields exactly one pulse regardless of hold time. REPEAT_DELAY and REPEAT_PERIOD are unused. All other behaviour is identical.

## Test plan
Parameters REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT_SEC=3 unless stated.
- Reset, then 4 `btn_mode` presses → `mode` 1,2,3,0; `clock_enable` 0 only at mode 3; no adjust pulses.
- SET_HOUR, hold `btn_up` 20 cycles → `hour_inc` pulses at cycles 1, 9, 13, 17 after the press. Without `WATCH_AUTOREPEAT_EN`, a single pulse at cycle 1.
- SET_MIN, `btn_up` and `btn_down` rise together → no pulse. `btn_mode` and `btn_up` rise together → mode 3, no `min_inc`.
- SET_MIN idle, 3 `tick_1hz` strobes → `mode`=0 after the 3rd. A `btn_up` press after the 2nd tick → 3 more ticks are needed.
- STOPWATCH: `btn_start` → `sw_run`=1; `btn_down` → no `sw_clear`; `btn_start` → `sw_run`=0; `btn_down` → one `sw_clear` pulse. Cycle mode back to TIME → `sw_run` unchanged.
- Assert `reset` during hold repeat in SET_HOUR with `btn_up` still high → mode 0, no pulses, no pulse after reset release until the button is re-pressed.

Source files
------------

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl
// ---------------------------------------------------------------------------
// Button-driven mode and time-set controller. Debounced button levels become
// mode state, one-clock hour/minute adjust pulses (with optional auto-repeat),
// stopwatch run/clear controls and display blink blanking.
//
// Optional feature macro: WATCH_AUTOREPEAT_EN
//   defined   -> holding exactly one of up/down auto-repeats the adjust pulse
//   undefined -> one pulse per press, REPEAT_DELAY/REPEAT_PERIOD unused
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   tick_1hz       one-clock strobe, once per second
//   btn_mode/up/down/start  debounced, synchronized levels (1 = pressed)
//   mode           0 TIME, 1 SET_HOUR, 2 SET_MIN, 3 STOPWATCH
//   clock_enable   1 = show time, 0 = show stopwatch
//   hour_inc/hour_dec/min_inc/min_dec  one-clock adjust pulses
//   sw_run         stopwatch running level
//   sw_clear       one-clock stopwatch clear pulse
//   blank_hours/blank_mins  blink blanking for the digit being set
// ---------------------------------------------------------------------------
module watch_mode_ctrl #(
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4,
    parameter int TIMEOUT_SEC   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    output logic [1:0] mode,
    output logic       clock_enable,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       min_inc,
    output logic       min_dec,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       blank_hours,
    output logic       blank_mins
);

    localparam logic [1:0] M_TIME     = 2'd0;
    localparam logic [1:0] M_SET_HOUR = 2'd1;
    localparam logic [1:0] M_SET_MIN  = 2'd2;
    localparam logic [1:0] M_SW       = 2'd3;

    localparam int B_MODE  = 0;
    localparam int B_UP    = 1;
    localparam int B_DOWN  = 2;
    localparam int B_START = 3;

    // Timeout counter runs 0..TIMEOUT_SEC-1; the tick that would reach
    // TIMEOUT_SEC performs the return to TIME instead.
    localparam int             TW       = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_SEC - 1);

    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || TIMEOUT_SEC < 1) begin : g_bad_param
        $error("watch_mode_ctrl: parameter below its minimum");
    end

    genvar gi;

    // ---------------- input sampling ----------------
    logic [3:0]    w_btn_raw;
    logic [3:0]    r_btn;
    logic [3:0]    r_prev;
    logic [3:0]    r_block;   // button seen held since reset; no edge until released
    logic [3:0]    w_edge;
    logic          r_tick;

    assign w_btn_raw = {btn_start, btn_down, btn_up, btn_mode};

    for (gi = 0; gi < 4; gi++) begin : g_edge
        assign w_edge[gi] = r_btn[gi] & ~r_prev[gi] & ~r_block[gi];
    end

    // ---------------- state ----------------
    logic [1:0]    r_mode;
    logic [TW-1:0] r_tmo;
    logic          r_phase;
    logic          r_inhibit;
    logic          r_sw_run;

    logic [1:0]    w_mode_next;
    logic [TW-1:0] w_tmo_next;
    logic          w_phase_next;
    logic          w_inhibit_next;
    logic          w_run_next;
    logic          w_fire_up;
    logic          w_fire_down;
    logic          w_fire_clear;
    logic          w_conflict;

`ifdef WATCH_AUTOREPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX);

    logic          r_hold_act;
    logic          r_hold_dir;    // 0 = up, 1 = down
    logic [HW-1:0] r_hold_cnt;    // cycles left until the next repeat pulse
    logic          w_hold_act_next;
    logic          w_hold_dir_next;
    logic [HW-1:0] w_hold_cnt_next;
    logic          w_held_same;
    logic          w_held_other;

    assign w_held_same  = r_hold_dir ? r_btn[B_DOWN] : r_btn[B_UP];
    assign w_held_other = r_hold_dir ? r_btn[B_UP]   : r_btn[B_DOWN];
`endif

    // ---------------- output registers ----------------
    logic r_clock_enable, r_hour_inc, r_hour_dec, r_min_inc, r_min_dec;
    logic r_sw_clear, r_blank_hours, r_blank_mins;
    logic w_clock_enable_next, w_hour_inc_next, w_hour_dec_next;
    logic w_min_inc_next, w_min_dec_next, w_sw_clear_next;
    logic w_blank_hours_next, w_blank_mins_next;

    // An edge on one of up/down while the other is held (or both together).
    assign w_conflict = (w_edge[B_UP] & r_btn[B_DOWN]) | (w_edge[B_DOWN] & r_btn[B_UP]);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn          <= '0;
            r_prev         <= '0;
            r_block        <= '1;
            r_tick         <= 1'b0;
            r_mode         <= M_TIME;
            r_tmo          <= '0;
            r_phase        <= 1'b0;
            r_inhibit      <= 1'b0;
            r_sw_run       <= 1'b0;
            r_clock_enable <= 1'b1;
            r_hour_inc     <= 1'b0;
            r_hour_dec     <= 1'b0;
            r_min_inc      <= 1'b0;
            r_min_dec      <= 1'b0;
            r_sw_clear     <= 1'b0;
            r_blank_hours  <= 1'b0;
            r_blank_mins   <= 1'b0;
`ifdef WATCH_AUTOREPEAT_EN
            r_hold_act     <= 1'b0;
            r_hold_dir     <= 1'b0;
            r_hold_cnt     <= '0;
`endif
        end else begin
            r_btn          <= w_btn_raw;
            r_prev         <= r_btn;
            r_block        <= r_block & w_btn_raw;
            r_tick         <= tick_1hz;
            r_mode         <= w_mode_next;
            r_tmo          <= w_tmo_next;
            r_phase        <= w_phase_next;
            r_inhibit      <= w_inhibit_next;
            r_sw_run       <= w_run_next;
            r_clock_enable <= w_clock_enable_next;
            r_hour_inc     <= w_hour_inc_next;
            r_hour_dec     <= w_hour_dec_next;
            r_min_inc      <= w_min_inc_next;
            r_min_dec      <= w_min_dec_next;
            r_sw_clear     <= w_sw_clear_next;
            r_blank_hours  <= w_blank_hours_next;
            r_blank_mins   <= w_blank_mins_next;
`ifdef WATCH_AUTOREPEAT_EN
            r_hold_act     <= w_hold_act_next;
            r_hold_dir     <= w_hold_dir_next;
            r_hold_cnt     <= w_hold_cnt_next;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_mode_next     = r_mode;
        w_tmo_next      = r_tmo;
        w_phase_next    = r_phase;
        w_inhibit_next  = r_inhibit;
        w_run_next      = r_sw_run;
        w_fire_up       = 1'b0;
        w_fire_down     = 1'b0;
        w_fire_clear    = 1'b0;
`ifdef WATCH_AUTOREPEAT_EN
        w_hold_act_next = r_hold_act;
        w_hold_dir_next = r_hold_dir;
        w_hold_cnt_next = r_hold_cnt;
`endif
        if (!r_btn[B_UP] && !r_btn[B_DOWN])
            w_inhibit_next = 1'b0;

        if (r_mode == M_SW && w_edge[B_START])
            w_run_next = ~r_sw_run;

        if (w_edge[B_MODE]) begin
            // Mode advance wins over up/down edges and restarts all counters.
            w_mode_next  = r_mode + 2'd1;
            w_tmo_next   = '0;
            w_phase_next = 1'b0;
`ifdef WATCH_AUTOREPEAT_EN
            w_hold_act_next = 1'b0;
`endif
        end else begin
            case (r_mode)
                M_SET_HOUR, M_SET_MIN: begin
                    if (w_conflict) begin
                        w_inhibit_next = 1'b1;
`ifdef WATCH_AUTOREPEAT_EN
                        w_hold_act_next = 1'b0;
`endif
                    end else if (w_edge[B_UP] || w_edge[B_DOWN]) begin
                        w_fire_up   = w_edge[B_UP];
                        w_fire_down = w_edge[B_DOWN];
`ifdef WATCH_AUTOREPEAT_EN
                        w_hold_act_next = ~r_inhibit;
                        w_hold_dir_next = w_edge[B_DOWN];
                        w_hold_cnt_next = HW'(REPEAT_DELAY - 1);
`endif
                    end
`ifdef WATCH_AUTOREPEAT_EN
                    else if (r_hold_act) begin
                        // Repeat only while the same single button is still held.
                        if (!w_held_same || w_held_other) begin
                            w_hold_act_next = 1'b0;
                        end else if (r_hold_cnt == '0) begin
                            w_fire_up       = ~r_hold_dir;
                            w_fire_down     = r_hold_dir;
                            w_hold_cnt_next = HW'(REPEAT_PERIOD - 1);
                        end else begin
                            w_hold_cnt_next = r_hold_cnt - 1'b1;
                        end
                    end
`endif
                    if (r_tick)
                        w_phase_next = ~r_phase;
                    if (|r_btn) begin
                        w_tmo_next = '0;
                    end else if (r_tick) begin
                        if (r_tmo == TMO_LAST) begin
                            w_mode_next  = M_TIME;
                            w_tmo_next   = '0;
                            w_phase_next = 1'b0;
`ifdef WATCH_AUTOREPEAT_EN
                            w_hold_act_next = 1'b0;
`endif
                        end else begin
                            w_tmo_next = r_tmo + 1'b1;
                        end
                    end
                end
                M_SW: begin
                    if (w_edge[B_DOWN] && !r_sw_run)
                        w_fire_clear = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_clock_enable_next = (w_mode_next != M_SW);
        w_hour_inc_next     = (r_mode == M_SET_HOUR) & w_fire_up;
        w_hour_dec_next     = (r_mode == M_SET_HOUR) & w_fire_down;
        w_min_inc_next      = (r_mode == M_SET_MIN)  & w_fire_up;
        w_min_dec_next      = (r_mode == M_SET_MIN)  & w_fire_down;
        w_sw_clear_next     = w_fire_clear;
        w_blank_hours_next  = (w_mode_next == M_SET_HOUR) & w_phase_next
                              & ~(r_btn[B_UP] | r_btn[B_DOWN]);
        w_blank_mins_next   = (w_mode_next == M_SET_MIN) & w_phase_next
                              & ~(r_btn[B_UP] | r_btn[B_DOWN]);
    end

    assign mode         = r_mode;
    assign clock_enable = r_clock_enable;
    assign hour_inc     = r_hour_inc;
    assign hour_dec     = r_hour_dec;
    assign min_inc      = r_min_inc;
    assign min_dec      = r_min_dec;
    assign sw_run       = r_sw_run;
    assign sw_clear     = r_sw_clear;
    assign blank_hours  = r_blank_hours;
    assign blank_mins   = r_blank_mins;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Testbench for watch_mode_ctrl. Stimulus pushes expected output events
// (kind, value, cycle) into a queue; a monitor detects every output change
// or pulse and pops/compares against the queue.
//   kind 1: {clock_enable, mode}   kind 2: sw_run
//   kind 0: {sw_clear, min_dec, min_inc, hour_dec, hour_inc}
//   kind 3: {blank_hours, blank_mins}
module tb_watch_mode_ctrl;

    localparam int RD = 8;
    localparam int RP = 4;
    localparam int TS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] btns = 4'b0000;   // {start, down, up, mode}
    logic [1:0] mode;
    logic       ce, hi, hd, mi, md, run, clr, bh, bm;

    always #5 clk = ~clk;

    watch_mode_ctrl #(
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .TIMEOUT_SEC  (TS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick),
        .btn_mode    (btns[0]),
        .btn_up      (btns[1]),
        .btn_down    (btns[2]),
        .btn_start   (btns[3]),
        .mode        (mode),
        .clock_enable(ce),
        .hour_inc    (hi),
        .hour_dec    (hd),
        .min_inc     (mi),
        .min_dec     (md),
        .sw_run      (run),
        .sw_clear    (clr),
        .blank_hours (bh),
        .blank_mins  (bm)
    );

    typedef struct {
        int k;
        int v;
        int c;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0:       return "pulse";
            1:       return "mode";
            2:       return "sw_run";
            default: return "blank";
        endcase
    endfunction

    task automatic exp_ev(input int k, input int v, input int dc);
        ev_t e;
        e.k = k;
        e.v = v;
        e.c = cyc + dc;
        q.push_back(e);
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s: got val=%0d at cyc=%0d, required no event", kname(k), v, cyc);
        end else begin
            e = q.pop_front();
            if (e.k != k || e.v != v || e.c != cyc) begin
                errors++;
                $display("FAIL %s: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                         kname(k), k, v, cyc, e.k, e.v, e.c);
            end else begin
                $display("ok   %s val=%0d cyc=%0d", kname(k), v, cyc);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    // Monitor: compares every observable output event against the queue.
    initial begin : monitor
        logic [2:0] last_mce;
        logic       last_run;
        logic [1:0] last_bl;
        last_mce = 3'b100;
        last_run = 1'b0;
        last_bl  = 2'b00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ({ce, mode} != last_mce) begin
                    observe(1, int'({ce, mode}));
                    last_mce = {ce, mode};
                end
                if (run != last_run) begin
                    observe(2, int'(run));
                    last_run = run;
                end
                if ({clr, md, mi, hd, hi} != 5'b0)
                    observe(0, int'({clr, md, mi, hd, hi}));
                if ({bh, bm} != last_bl) begin
                    observe(3, int'({bh, bm}));
                    last_bl = {bh, bm};
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] b, input int hold);
        btns = b;
        wait_cyc(hold);
        btns = 4'b0000;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        wait_cyc(1);
        tick = 1'b0;
        wait_cyc(3);
    endtask

    // Stimulus: drive at negedge cycle c; a sampled edge shows at cycle c+2.
    initial begin : stimulus
        int mode_seq[4];
        mode_seq = '{5, 6, 3, 4};

        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        chk("reset mode", int'(mode), 0);
        chk("reset clock_enable", int'(ce), 1);
        chk("reset sw_run", int'(run), 0);
        chk("reset pulses", int'({clr, md, mi, hd, hi}), 0);
        chk("reset blanks", int'({bh, bm}), 0);
        mon_en = 1'b1;

        // Mode cycle TIME->SET_HOUR->SET_MIN->STOPWATCH->TIME
        for (int i = 0; i < 4; i++) begin
            exp_ev(1, mode_seq[i], 2);
            press(4'b0001, 1);
            wait_cyc(3);
        end

        // SET_HOUR: held up gives initial pulse plus repeats
        exp_ev(1, 5, 2);
        press(4'b0001, 1);
        wait_cyc(3);
        exp_ev(0, 1, 2);
`ifdef WATCH_AUTOREPEAT_EN
        exp_ev(0, 1, 2 + RD);
        exp_ev(0, 1, 2 + RD + RP);
        exp_ev(0, 1, 2 + RD + 2 * RP);
`endif
        press(4'b0010, 20);
        wait_cyc(8);

        // SET_HOUR: down -> hour_dec
        exp_ev(0, 2, 2);
        press(4'b0100, 1);
        wait_cyc(3);

        // Blink: tick sets phase, button press suppresses blanking
        exp_ev(3, 2, 2);
        pulse_tick();
        exp_ev(0, 1, 2);
        exp_ev(3, 0, 2);
        exp_ev(3, 2, 3);
        press(4'b0010, 1);
        wait_cyc(4);

        // Into SET_MIN: blink phase cleared
        exp_ev(1, 6, 2);
        exp_ev(3, 0, 2);
        press(4'b0001, 1);
        wait_cyc(3);

        exp_ev(0, 4, 2);
        press(4'b0010, 1);
        wait_cyc(3);
        exp_ev(0, 8, 2);
        press(4'b0100, 1);
        wait_cyc(3);

        // up and down together: nothing
        press(4'b0110, 1);
        wait_cyc(3);

        // down held, then up: only the initial min_dec, repeat inhibited
        exp_ev(0, 8, 2);
        btns = 4'b0100;
        wait_cyc(3);
        btns = 4'b0110;
        wait_cyc(12);
        btns = 4'b0000;
        wait_cyc(3);

        // mode and up together: mode wins, no min_inc
        exp_ev(1, 3, 2);
        press(4'b0011, 1);
        wait_cyc(3);

        // STOPWATCH
        exp_ev(2, 1, 2);
        press(4'b1000, 1);
        wait_cyc(3);
        press(4'b0100, 1);           // running: no clear
        wait_cyc(3);
        exp_ev(2, 0, 2);
        press(4'b1000, 1);
        wait_cyc(3);
        exp_ev(0, 16, 2);
        press(4'b0100, 1);
        wait_cyc(3);
        exp_ev(2, 1, 2);
        press(4'b1000, 1);
        wait_cyc(3);
        exp_ev(1, 4, 2);             // back to TIME, sw_run stays 1
        press(4'b0001, 1);
        wait_cyc(3);
        press(4'b1000, 1);           // start ignored in TIME
        wait_cyc(3);

        // Timeout: SET_MIN idle, 3 ticks
        exp_ev(1, 5, 2);
        press(4'b0001, 1);
        wait_cyc(3);
        exp_ev(1, 6, 2);
        press(4'b0001, 1);
        wait_cyc(3);
        exp_ev(3, 1, 2);
        pulse_tick();
        exp_ev(3, 0, 2);
        pulse_tick();
        exp_ev(1, 4, 2);
        pulse_tick();

        // Timeout restarted by a press after the 2nd tick
        exp_ev(1, 5, 2);
        press(4'b0001, 1);
        wait_cyc(3);
        exp_ev(1, 6, 2);
        press(4'b0001, 1);
        wait_cyc(3);
        exp_ev(3, 1, 2);
        pulse_tick();
        exp_ev(3, 0, 2);
        pulse_tick();
        exp_ev(0, 4, 2);
        press(4'b0010, 1);
        wait_cyc(3);
        exp_ev(3, 1, 2);
        pulse_tick();
        exp_ev(3, 0, 2);
        pulse_tick();
        exp_ev(1, 4, 2);
        pulse_tick();

        // Reset during hold in SET_HOUR
        exp_ev(1, 5, 2);
        press(4'b0001, 1);
        wait_cyc(3);
        btns = 4'b0010;
        exp_ev(0, 1, 2);
`ifdef WATCH_AUTOREPEAT_EN
        exp_ev(0, 1, 2 + RD);
`endif
        wait_cyc(12);
        reset = 1'b1;
        exp_ev(1, 4, 1);
        exp_ev(2, 0, 1);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(3);
        // up still held: enter SET_HOUR, no pulse until re-pressed
        exp_ev(1, 5, 2);
        btns = 4'b0011;
        wait_cyc(1);
        btns = 4'b0010;
        wait_cyc(15);
        btns = 4'b0000;
        wait_cyc(3);
        exp_ev(0, 1, 2);
        press(4'b0010, 1);
        wait_cyc(6);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing events: got %0d outstanding, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
